// File: rtl/aes_key_scheduler_if.sv
// Key-schedule bus between a key source and aes_key_scheduler.
//   key_in[255:0]  cipher key; a 128-bit key sits in [255:128]
//   key_mode[1:0]  00 = AES-128, 10 = AES-256, 01/11 = reserved
//   key_valid      source offers key_in/key_mode
//   key_ready      scheduler can accept a key
//   keys_ready     round-key store is complete for the current key
//   err            one-cycle pulse after a reserved-mode key is accepted
//   rk_idx[3:0]    round-key read index
//   rk_data[127:0] registered round key for rk_idx
// master: key source / reader side. slave: the scheduler.
interface aes_key_scheduler_if;
    logic [255:0] key_in;
    logic [1:0]   key_mode;
    logic         key_valid;
    logic         key_ready;
    logic         keys_ready;
    logic         err;
    logic [3:0]   rk_idx;
    logic [127:0] rk_data;

    modport master (
        output key_in,
        output key_mode,
        output key_valid,
        output rk_idx,
        input  key_ready,
        input  keys_ready,
        input  err,
        input  rk_data
    );

    modport slave (
        input  key_in,
        input  key_mode,
        input  key_valid,
        input  rk_idx,
        output key_ready,
        output keys_ready,
        output err,
        output rk_data
    );
endinterface

// File: rtl/aes_roundkey.sv
// Combinational AES round-key generator: produces round key RD from the two
// preceding round keys.
//   RD[3:0]            index of the round key being produced
//   mode[1:0]          00 = AES-128, 10 = AES-256
//   prev_key[127:0]    round key RD-2 (only used for AES-256)
//   current_key[127:0] round key RD-1
//   round_key[127:0]   round key RD
module aes_roundkey (
    input  logic [3:0]   RD,
    input  logic [1:0]   mode,
    input  logic [127:0] prev_key,
    input  logic [127:0] current_key,
    output logic [127:0] round_key
);
    // Byte 0x00 lives in the top byte.
    localparam logic [2047:0] SBox = {
        128'h637c777b_f26b6fc5_3001672b_fed7ab76,
        128'hca82c97d_fa5947f0_add4a2af_9ca472c0,
        128'hb7fd9326_363ff7cc_34a5e5f1_71d83115,
        128'h04c723c3_1896059a_071280e2_eb27b275,
        128'h09832c1a_1b6e5aa0_523bd6b3_29e32f84,
        128'h53d100ed_20fcb15b_6acbbe39_4a4c58cf,
        128'hd0efaafb_434d3385_45f9027f_503c9fa8,
        128'h51a3408f_929d38f5_bcb6da21_10fff3d2,
        128'hcd0c13ec_5f974417_c4a77e3d_645d1973,
        128'h60814fdc_222a9088_46eeb814_de5e0bdb,
        128'he0323a0a_4906245c_c2d3ac62_9195e479,
        128'he7c8376d_8dd54ea9_6c56f4ea_657aae08,
        128'hba78252e_1ca6b4c6_e8dd741f_4bbd8b8a,
        128'h703eb566_4803f60e_613557b9_86c11d9e,
        128'he1f89811_69d98e94_9b1e87e9_ce5528df,
        128'h8ca1890d_bfe64268_41992d0f_b054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        // Offset of byte b is 8 * (255 - b) = {~b, 3'b000}.
        return SBox[{~b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    logic         is_256;
    logic [3:0]   rcon_idx;
    logic [7:0]   rcon;
    logic [31:0]  last_word;
    logic [31:0]  temp;
    logic [127:0] base;
    logic [31:0]  w0, w1, w2, w3;

    always_comb begin
        is_256    = (mode == 2'b10);
        // AES-256 words XOR with the key two rounds back (Nk = 8 words).
        base      = is_256 ? prev_key : current_key;
        last_word = current_key[31:0];
        // AES-256 only applies Rcon on even round keys, one Rcon per pair.
        rcon_idx  = is_256 ? {1'b0, RD[3:1]} : RD;

        case (rcon_idx)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase

        // Odd AES-256 round keys use SubWord without rotation or Rcon.
        if (is_256 && RD[0]) begin
            temp = sub_word(last_word);
        end else begin
            temp = sub_word({last_word[23:0], last_word[31:24]}) ^ {rcon, 24'h0};
        end

        w0        = base[127:96] ^ temp;
        w1        = base[95:64]  ^ w0;
        w2        = base[63:32]  ^ w1;
        w3        = base[31:0]   ^ w2;
        round_key = {w0, w1, w2, w3};
    end
endmodule

// File: rtl/aes_key_scheduler.sv
// AES key scheduler: accepts an AES-128 or AES-256 key, expands it one round
// key per cycle into a 15-entry store and serves registered reads from it.
//   clk    rising-edge clock
//   rst_n  synchronous active-low reset
//   bus    aes_key_scheduler_if.slave (key handshake, status, round-key read)
module aes_key_scheduler (
    input  logic               clk,
    input  logic               rst_n,
    aes_key_scheduler_if.slave bus
);
    localparam int unsigned NumRk = 15;

    typedef enum logic [1:0] {StIdle, StGen, StDone} state_e;

    state_e       state_q, state_d;
    logic [3:0]   rd_q, rd_d;
    logic [1:0]   mode_q, mode_d;
    logic         err_q, err_d;
    logic [127:0] rk_data_q, rk_data_d;
    logic [127:0] rk_q [NumRk];

    logic             key_ready;
    logic             load_128;
    logic             load_256;
    logic             gen_step;
    logic [3:0]       last_idx;
    logic [3:0]       cur_idx;
    logic [3:0]       prev_idx;
    logic [127:0]     cur_key;
    logic [127:0]     prev_key;
    logic [127:0]     round_key;
    logic [NumRk-1:0] rk_we;
    logic [127:0]     rk_wdata [NumRk];

    assign key_ready      = (state_q != StGen);
    assign bus.key_ready  = key_ready;
    assign bus.keys_ready = (state_q == StDone);
    assign bus.err        = err_q;
    assign bus.rk_data    = rk_data_q;

    assign last_idx = (mode_q == 2'b10) ? 4'd14 : 4'd10;

    // Operands for the round generator: RK[RD-1] and RK[RD-2] (zero at RD = 1).
    always_comb begin
        cur_idx  = rd_q - 4'd1;
        prev_idx = rd_q - 4'd2;
        cur_key  = '0;
        prev_key = '0;
        for (int unsigned i = 0; i < NumRk; i++) begin
            if (cur_idx == 4'(i)) begin
                cur_key = rk_q[i];
            end
            if (rd_q != 4'd1 && prev_idx == 4'(i)) begin
                prev_key = rk_q[i];
            end
        end
    end

    aes_roundkey u_roundkey (
        .RD          (rd_q),
        .mode        (mode_q),
        .prev_key    (prev_key),
        .current_key (cur_key),
        .round_key   (round_key)
    );

    // Control FSM.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        mode_d   = mode_q;
        err_d    = 1'b0;
        load_128 = 1'b0;
        load_256 = 1'b0;
        gen_step = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.key_valid) begin
                    case (bus.key_mode)
                        2'b00: begin
                            load_128 = 1'b1;
                            mode_d   = 2'b00;
                            rd_d     = 4'd1;
                            state_d  = StGen;
                        end
                        2'b10: begin
                            load_256 = 1'b1;
                            mode_d   = 2'b10;
                            rd_d     = 4'd2;
                            state_d  = StGen;
                        end
                        default: begin
                            // Reserved mode: store and latched mode untouched.
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    endcase
                end
            end
            StGen: begin
                gen_step = 1'b1;
                // RD stops at the last index so it never exceeds 14.
                if (rd_q == last_idx) begin
                    state_d = StDone;
                end else begin
                    rd_d = rd_q + 4'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Store write enables and data.
    always_comb begin
        rk_we = '0;
        for (int unsigned i = 0; i < NumRk; i++) begin
            rk_wdata[i] = round_key;
        end
        rk_wdata[0] = bus.key_in[255:128];
        rk_wdata[1] = load_256 ? bus.key_in[127:0] : round_key;
        rk_we[0]    = load_128 | load_256;
        rk_we[1]    = load_256;
        for (int unsigned i = 0; i < NumRk; i++) begin
            if (gen_step && rd_q == 4'(i)) begin
                rk_we[i] = 1'b1;
            end
        end
    end

    // Registered read port; indices past the last key of the mode read zero.
    always_comb begin
        rk_data_d = '0;
        for (int unsigned i = 0; i < NumRk; i++) begin
            if (bus.rk_idx == 4'(i) && bus.rk_idx <= last_idx) begin
                rk_data_d = rk_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            rd_q      <= 4'd0;
            mode_q    <= 2'b00;
            err_q     <= 1'b0;
            rk_data_q <= '0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            mode_q    <= mode_d;
            err_q     <= err_d;
            rk_data_q <= rk_data_d;
        end
    end

    // Round-key store has no reset; writes are blocked while reset is asserted.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int unsigned i = 0; i < NumRk; i++) begin
                if (rk_we[i]) begin
                    rk_q[i] <= rk_wdata[i];
                end
            end
        end
    end
endmodule

// File: doc/aes_key_scheduler.md
AES_KEY_SCHEDULER -- requirements
Module: aes_key_scheduler

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset, with ports as follows:
- clk  in  1  rising-edge clock; all state updates on this edge.
- rst_n  in  1  reset, synchronous, active-low.
- key_in  in  256  cipher key; 128-bit keys occupy [255:128].
- key_mode  in  2  00 = AES-128, 10 = AES-256, 01/11 = reserved.
- key_valid  in  1  key_in/key_mode offered.
- key_ready  out  1  block can accept a key.
- keys_ready  out  1  round-key store complete and valid for the current key.
- err  out  1  one-cycle pulse when a key with reserved mode is accepted.
- rk_idx  in  4  round-key read index.
- rk_data  out  128  registered round key for rk_idx.
REQ-002 The block SHALL instantiate the codebase's aes_roundkey (RD[3:0], mode[1:0], prev_key[127:0], current_key[127:0] -> round_key[127:0], combinational) as its round generator.

Function
REQ-003 States SHALL be IDLE, GEN and DONE.
- key_ready = 1 in IDLE and DONE, 0 in GEN.
- keys_ready = 1 only in DONE.
REQ-004 Acceptance SHALL occur on an edge where key_valid && key_ready.
- Mode 00: RK[0] <= key_in[255:128]; RD <= 1; go to GEN.
- Mode 10: RK[0] <= key_in[255:128], RK[1] <= key_in[127:0]; RD <= 2; go to GEN.
- Mode 01/11: no store write; err = 1 for the following cycle; go to IDLE.
REQ-005 Each GEN cycle SHALL drive aes_roundkey as follows:
- RD = RD counter.
- mode = latched key_mode.
- current_key = RK[RD-1].
- prev_key = RK[RD-2] (128'h0 when RD = 1).
- At the edge, RK[RD] <= round_key and RD increments by 1.
REQ-006 GEN SHALL go to DONE on the edge that writes the last key: RK[10] for mode 00, RK[14] for mode 10.
- keys_ready is high 10 cycles (AES-128) or 13 cycles (AES-256) after the acceptance edge.
REQ-007 The store SHALL be 15 x 128-bit registers, written only as defined in REQ-004 and REQ-005; the store has no reset.
REQ-008 rk_data SHALL be registered with 1-cycle read latency: rk_data <= RK[rk_idx] when rk_idx <= last index of the latched mode, else 128'h0.
REQ-009 rk_data SHALL be meaningful only while keys_ready = 1; during GEN, reads return current store contents without guarantee.
REQ-010 Accepting a new key in DONE SHALL drop keys_ready on that edge and restart generation per REQ-004; earlier keys are overwritten progressively.
REQ-011 key_valid asserted during GEN SHALL be ignored; the offering source holds key_in/key_mode until key_ready.
REQ-012 The RD counter SHALL be 4 bits wide and SHALL never exceed 14 or wrap; key_mode is latched at acceptance and SHALL NOT be re-sampled during GEN.

Reset
REQ-013 When rst_n = 0 at an edge, the block SHALL reset from any state, including mid-GEN:
- state = IDLE, RD = 0, latched mode = 00.
- key_ready = 1 after that edge; keys_ready = 0, err = 0, rk_data = 128'h0.
- Store contents are don't-care; no partial schedule is reported as valid.
REQ-014 A key offered in the same cycle as rst_n = 0 SHALL NOT be accepted.

Verification
REQ-015 AES-256, key_in = 256'h1, mode 10, checks:
- keys_ready rises exactly 13 cycles after acceptance.
- RK[1] = 00000000000000000000000000000001.
- RK[2] = 62637c6362637c6362637c6362637c63.
- RK[6] = f9c831c1f4021c6d9bab4da29661600e.
- RK[14] = d31a3c17d24b743ba788d2bf71a936f3.
REQ-016 AES-128, key_in = 256'h0, mode 00, checks:
- keys_ready rises 10 cycles after acceptance.
- RK[1] = 62636363626363636263636362636363.
- RK[10] = b4ef5bcb3e92e21123e951cf6f8f188e.
- rk_idx = 11 returns 128'h0.
REQ-017 Reserved mode 11 with key_valid = 1:
- err pulses for exactly 1 cycle.
- keys_ready stays 0; key_ready stays 1.
- A following valid AES-256 key generates correctly.
REQ-018 Reset mid-GEN, rst_n low 1 cycle after 5 GEN cycles:
- keys_ready = 0 and key_ready = 1 after the edge.
- A new AES-256 key (256'h1) then matches all REQ-015 values.
REQ-019 Back-to-back keys, second offered the cycle keys_ready rises:
- Accepted immediately; keys_ready falls on that edge.
- Second schedule completes with correct RK[14].
- key_valid held throughout GEN is never double-accepted.
REQ-020 Read latency: change rk_idx each cycle in DONE; rk_data tracks with exactly 1-cycle delay for all indices 0..15.
